// File: rtl/btn_mode_arbiter.sv
// ---------------------------------------------------------------------------
// btn_mode_arbiter
//
// Front-end for the DigitalClock board inputs. It synchronises the slide
// switches and push-buttons, debounces every button, and turns each debounced
// rising edge into a one-cycle event. That event goes to exactly one consumer
// bus, chosen by the active mode. Around every mode change, and after reset,
// button traffic is blocked. The block lifts only after a fixed window has
// elapsed and every button has been released, so a press can never leak
// across modes.
//
// Parameters
//   N_BTN        number of push-buttons
//   DEBOUNCE_MS  stable cycles before a debounced level changes (1 cycle = 1 ms)
//   BLOCK_MS     blocking window length; must exceed DEBOUNCE_MS + 2
//
// Ports
//   clk_1k         1 kHz system clock
//   clr_sw_n       asynchronous active-low reset
//   alarm_sw       raw alarm-mode switch       (highest priority)
//   stopwatch_sw   raw stopwatch-mode switch
//   timer_sw       raw timer-mode switch       (lowest priority)
//   btn            raw active-high buttons
//   mode           active mode: 0 clock, 1 alarm, 2 stopwatch, 3 timer
//   clk_btn_pulse  button events for the clock-set datapath
//   alm_btn_pulse  button events for the alarm datapath
//   sw_btn_pulse   button events for the stopwatch datapath
//   tmr_btn_pulse  button events for the timer datapath
//   mode_change    one-cycle pulse on every change of mode
//   blocked        high while button events are suppressed
// ---------------------------------------------------------------------------
module btn_mode_arbiter #(
    parameter int N_BTN       = 9,
    parameter int DEBOUNCE_MS = 20,
    parameter int BLOCK_MS    = 100
) (
    input  logic             clk_1k,
    input  logic             clr_sw_n,
    input  logic             alarm_sw,
    input  logic             stopwatch_sw,
    input  logic             timer_sw,
    input  logic [N_BTN-1:0] btn,
    output logic [1:0]       mode,
    output logic [N_BTN-1:0] clk_btn_pulse,
    output logic [N_BTN-1:0] alm_btn_pulse,
    output logic [N_BTN-1:0] sw_btn_pulse,
    output logic [N_BTN-1:0] tmr_btn_pulse,
    output logic             mode_change,
    output logic             blocked
);

    localparam int DB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int BLK_W = $clog2(BLOCK_MS + 1);

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_ALARM     = 2'd1,
        MODE_STOPWATCH = 2'd2,
        MODE_TIMER     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_BLOCK,
        S_WAIT_REL,
        S_ACTIVE
    } state_e;

    // ---------------- input synchronisers ----------------
    // Switch bit order: [0] alarm, [1] stopwatch, [2] timer.
    logic [2:0]       sw_meta, sw_sync;
    logic [N_BTN-1:0] btn_meta, btn_sync;

    // NOTE: sequential state is always written with non-blocking assignments,
    // so every flop samples the values from before the edge.
    always_ff @(posedge clk_1k or negedge clr_sw_n) begin
        if (!clr_sw_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= {timer_sw, stopwatch_sw, alarm_sw};
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // ---------------- debounce + edge detect ----------------
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] deb, deb_d;
    logic [N_BTN-1:0] rise;

    // NOTE: db_cnt is an array of ordinary flops rather than a RAM, so it is
    // cleared element by element in reset like any other register.
    always_ff @(posedge clk_1k or negedge clr_sw_n) begin
        if (!clr_sw_n) begin
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
            deb   <= '0;
            deb_d <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_sync[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_MS)) begin
                    deb[i]    <= btn_sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only press edges are events; releases are silent.
    assign rise = deb & ~deb_d;

    // ---------------- mode resolution ----------------
    mode_e resolved_mode;

    // NOTE: the default assignment up front keeps this block purely
    // combinational; without it an uncovered path would infer a latch.
    always_comb begin
        resolved_mode = MODE_CLOCK;
        if (sw_sync[0])      resolved_mode = MODE_ALARM;
        else if (sw_sync[1]) resolved_mode = MODE_STOPWATCH;
        else if (sw_sync[2]) resolved_mode = MODE_TIMER;
    end

    // ---------------- blocking FSM + event routing ----------------
    // mode_req registers the resolved mode once more, which places the mode
    // update three edges after a switch edge is first sampled.
    state_e           state;
    mode_e            mode_req;
    logic [BLK_W-1:0] blk_cnt;

    always_ff @(posedge clk_1k or negedge clr_sw_n) begin
        if (!clr_sw_n) begin
            state         <= S_BLOCK;
            mode_req      <= MODE_CLOCK;
            blk_cnt       <= '0;
            mode          <= MODE_CLOCK;
            mode_change   <= 1'b0;
            blocked       <= 1'b1;
            clk_btn_pulse <= '0;
            alm_btn_pulse <= '0;
            sw_btn_pulse  <= '0;
            tmr_btn_pulse <= '0;
        end else begin
            mode_req      <= resolved_mode;
            mode_change   <= 1'b0;
            clk_btn_pulse <= '0;
            alm_btn_pulse <= '0;
            sw_btn_pulse  <= '0;
            tmr_btn_pulse <= '0;

            if (mode_req != mode) begin
                // A mode change outranks everything, including a rise landing
                // on this edge, and restarts the window from any state.
                mode        <= mode_req;
                mode_change <= 1'b1;
                blk_cnt     <= '0;
                state       <= S_BLOCK;
                blocked     <= 1'b1;
            end else begin
                case (state)
                    S_BLOCK: begin
                        if (blk_cnt == BLK_W'(BLOCK_MS)) begin
                            blk_cnt <= '0;
                            state   <= S_WAIT_REL;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end
                    S_WAIT_REL: begin
                        // Buttons held across the change must be released
                        // before anything can fire in the new mode.
                        if (deb == '0) begin
                            state   <= S_ACTIVE;
                            blocked <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        case (mode)
                            MODE_CLOCK:     clk_btn_pulse <= rise;
                            MODE_ALARM:     alm_btn_pulse <= rise;
                            MODE_STOPWATCH: sw_btn_pulse  <= rise;
                            MODE_TIMER:     tmr_btn_pulse <= rise;
                            default:        clk_btn_pulse <= '0;
                        endcase
                    end
                    default: begin
                        state   <= S_BLOCK;
                        blk_cnt <= '0;
                        blocked <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_mode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_btn_mode_arbiter
//
// Self-checking bench for btn_mode_arbiter with DEBOUNCE_MS=4, BLOCK_MS=10.
// A reference model keeps the history of raw input samples and computes the
// outputs from the timing rules. A debounced level flips once the last
// DEBOUNCE_MS+1 samples, ending two edges back, all disagree with it. The
// mode follows the resolved switches sampled three edges back. Events pass
// only once a full window has elapsed since the last block start and every
// button is up. The model is compared with the DUT on every clock, and
// directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_btn_mode_arbiter;

    localparam int N  = 9;
    localparam int D  = 4;
    localparam int B  = 10;
    localparam int HMAX = 8192;

    logic         clk_1k = 1'b0;
    logic         clr_sw_n = 1'b0;
    logic         alarm_sw = 1'b0;
    logic         stopwatch_sw = 1'b0;
    logic         timer_sw = 1'b0;
    logic [N-1:0] btn = '0;
    logic [1:0]   mode;
    logic [N-1:0] clk_btn_pulse, alm_btn_pulse, sw_btn_pulse, tmr_btn_pulse;
    logic         mode_change, blocked;

    btn_mode_arbiter #(.N_BTN(N), .DEBOUNCE_MS(D), .BLOCK_MS(B)) dut (
        .clk_1k        (clk_1k),
        .clr_sw_n      (clr_sw_n),
        .alarm_sw      (alarm_sw),
        .stopwatch_sw  (stopwatch_sw),
        .timer_sw      (timer_sw),
        .btn           (btn),
        .mode          (mode),
        .clk_btn_pulse (clk_btn_pulse),
        .alm_btn_pulse (alm_btn_pulse),
        .sw_btn_pulse  (sw_btn_pulse),
        .tmr_btn_pulse (tmr_btn_pulse),
        .mode_change   (mode_change),
        .blocked       (blocked)
    );

    always #5 clk_1k = ~clk_1k;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           edge_n = 0;          // edges since reset release
    logic [N-1:0] btn_s [HMAX];
    logic [1:0]   res_s [HMAX];
    logic [N-1:0] m_deb = '0, m_deb_prev = '0;
    logic [1:0]   m_mode = 2'd0;
    logic         m_mc = 1'b0;
    logic         m_active = 1'b0;
    int           blk_start = 0;
    logic [N-1:0] m_bus [4];

    function automatic logic [1:0] resolve(input logic a, input logic s, input logic t);
        return a ? 2'd1 : s ? 2'd2 : t ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [N-1:0] btn_at(input int idx);
        return (idx < 1) ? '0 : btn_s[idx];
    endfunction

    function automatic logic [1:0] res_at(input int idx);
        return (idx < 1) ? 2'd0 : res_s[idx];
    endfunction

    // Observed DUT activity, consumed by the directed scenarios.
    int pcnt  [4][N];
    int pedge [4][N];
    int mc_cnt = 0;
    int mc_edge = -1;
    int blk_fall_edge = -1;
    logic prev_blocked = 1'b1;

    task automatic clear_counts();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++) begin
                pcnt[b][i]  = 0;
                pedge[b][i] = -1;
            end
        mc_cnt = 0;
    endtask

    function automatic int total_pulses();
        int s = 0;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++) s += pcnt[b][i];
        return s;
    endfunction

    always @(posedge clk_1k) begin
        logic [N-1:0] rise, deb_before, new_deb;
        logic [1:0]   req;
        bit           stable;
        for (int b = 0; b < 4; b++) m_bus[b] = '0;
        m_mc = 1'b0;
        if (!clr_sw_n) begin
            edge_n = 0; m_deb = '0; m_deb_prev = '0; m_mode = 2'd0;
            m_active = 1'b0; blk_start = 0;
        end else begin
            edge_n++;
            if (edge_n < HMAX) begin
                btn_s[edge_n] = btn;
                res_s[edge_n] = resolve(alarm_sw, stopwatch_sw, timer_sw);
            end
            rise       = m_deb & ~m_deb_prev;
            deb_before = m_deb;
            new_deb    = m_deb;
            for (int i = 0; i < N; i++) begin
                stable = 1'b1;
                for (int j = edge_n - 2 - D; j <= edge_n - 2; j++) begin
                    logic [N-1:0] s;
                    s = btn_at(j);
                    if (s[i] == m_deb[i]) stable = 1'b0;
                end
                if (stable) new_deb[i] = ~m_deb[i];
            end
            m_deb_prev = m_deb;
            m_deb      = new_deb;
            req = res_at(edge_n - 3);
            if (req != m_mode) begin
                m_mode = req; m_mc = 1'b1; m_active = 1'b0; blk_start = edge_n;
            end else if (m_active) begin
                m_bus[m_mode] = rise;
            end else if (edge_n >= blk_start + B + 2 && deb_before == '0) begin
                m_active = 1'b1;
            end
        end

        #1;
        check("mode", 32'(mode), 32'(m_mode));
        check("mode_change", 32'(mode_change), 32'(m_mc));
        check("blocked", 32'(blocked), 32'(!m_active));
        check("clk_btn_pulse", 32'(clk_btn_pulse), 32'(m_bus[0]));
        check("alm_btn_pulse", 32'(alm_btn_pulse), 32'(m_bus[1]));
        check("sw_btn_pulse", 32'(sw_btn_pulse), 32'(m_bus[2]));
        check("tmr_btn_pulse", 32'(tmr_btn_pulse), 32'(m_bus[3]));
        check("busy_buses_le1",
              32'(((clk_btn_pulse != 0) + (alm_btn_pulse != 0) +
                   (sw_btn_pulse != 0) + (tmr_btn_pulse != 0)) <= 1), 32'd1);

        for (int i = 0; i < N; i++) begin
            if (clk_btn_pulse[i]) begin pcnt[0][i]++; pedge[0][i] = edge_n; end
            if (alm_btn_pulse[i]) begin pcnt[1][i]++; pedge[1][i] = edge_n; end
            if (sw_btn_pulse[i])  begin pcnt[2][i]++; pedge[2][i] = edge_n; end
            if (tmr_btn_pulse[i]) begin pcnt[3][i]++; pedge[3][i] = edge_n; end
        end
        if (mode_change) begin mc_cnt++; mc_edge = edge_n; end
        if (prev_blocked && !blocked) blk_fall_edge = edge_n;
        prev_blocked = blocked;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_1k);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int press_edge, sw_edge, idx;
        clear_counts();

        // 1. Reset, idle, then a single long press in clock mode.
        clr_sw_n = 1'b0;
        wait_cycles(3);
        clr_sw_n = 1'b1;
        wait_cycles(20);
        check("t1_mode", 32'(mode), 32'd0);
        check("t1_blocked_fall_edge", 32'(blk_fall_edge), 32'd12);
        check("t1_no_pulses", 32'(total_pulses()), 32'd0);
        press_edge = edge_n + 1;
        btn[0] = 1'b1;
        wait_cycles(50);
        btn[0] = 1'b0;
        wait_cycles(15);
        check("t1_clk_pulse_count", 32'(pcnt[0][0]), 32'd1);
        check("t1_pulse_latency", 32'(pedge[0][0] - press_edge), 32'd7);
        check("t1_total_pulses", 32'(total_pulses()), 32'd1);

        // 2. Bouncing button, then a clean hold.
        clear_counts();
        repeat (5) begin
            btn[3] = 1'b1; wait_cycles(2);
            btn[3] = 1'b0; wait_cycles(2);
        end
        check("t2_no_pulse_while_bouncing", 32'(total_pulses()), 32'd0);
        press_edge = edge_n + 1;
        btn[3] = 1'b1;
        wait_cycles(20);
        btn[3] = 1'b0;
        wait_cycles(15);
        check("t2_pulse_count", 32'(pcnt[0][3]), 32'd1);
        check("t2_pulse_latency", 32'(pedge[0][3] - press_edge), 32'd7);

        // 3. Timer mode routing.
        clear_counts();
        sw_edge = edge_n + 1;
        timer_sw = 1'b1;
        wait_cycles(5);
        check("t3_mode", 32'(mode), 32'd3);
        check("t3_mode_change_count", 32'(mc_cnt), 32'd1);
        check("t3_mode_latency", 32'(mc_edge - sw_edge), 32'd3);
        check("t3_blocked", 32'(blocked), 32'd1);
        wait_cycles(15);
        btn[0] = 1'b1;
        wait_cycles(10);
        btn[0] = 1'b0;
        wait_cycles(10);
        check("t3_tmr_pulse", 32'(pcnt[3][0]), 32'd1);
        check("t3_total_pulses", 32'(total_pulses()), 32'd1);

        // 4. Priority and button held across the mode change.
        btn[1] = 1'b1;
        wait_cycles(10);
        clear_counts();
        alarm_sw = 1'b1;
        stopwatch_sw = 1'b1;
        wait_cycles(30);
        btn[1] = 1'b0;
        wait_cycles(20);
        check("t4_mode", 32'(mode), 32'd1);
        check("t4_mode_change_count", 32'(mc_cnt), 32'd1);
        check("t4_no_leak", 32'(total_pulses()), 32'd0);
        check("t4_active_after_release", 32'(blocked), 32'd0);
        btn[1] = 1'b1;
        wait_cycles(10);
        btn[1] = 1'b0;
        wait_cycles(10);
        check("t4_alm_pulse", 32'(pcnt[1][1]), 32'd1);

        // 5. Simultaneous presses.
        clear_counts();
        press_edge = edge_n + 1;
        btn[2] = 1'b1;
        btn[5] = 1'b1;
        wait_cycles(10);
        btn[2] = 1'b0;
        btn[5] = 1'b0;
        wait_cycles(10);
        check("t5_bit2", 32'(pcnt[1][2]), 32'd1);
        check("t5_bit5", 32'(pcnt[1][5]), 32'd1);
        check("t5_same_cycle", 32'(pedge[1][2]), 32'(pedge[1][5]));
        check("t5_latency", 32'(pedge[1][5] - press_edge), 32'd7);
        check("t5_total_pulses", 32'(total_pulses()), 32'd2);

        // 6. Mode changes inside the window, then reset mid-window.
        alarm_sw = 1'b0;
        stopwatch_sw = 1'b0;           // timer_sw still high -> mode 3
        wait_cycles(5);
        clear_counts();
        timer_sw = 1'b0;
        wait_cycles(6);
        timer_sw = 1'b1;
        wait_cycles(5);
        check("t6_mode_change_count", 32'(mc_cnt), 32'd2);
        check("t6_mode", 32'(mode), 32'd3);
        wait_cycles(20);
        check("t6_window_restart", 32'(blk_fall_edge - mc_edge), 32'd12);
        timer_sw = 1'b0;
        wait_cycles(8);
        clr_sw_n = 1'b0;
        #1;
        check("t6_async_mode", 32'(mode), 32'd0);
        check("t6_async_blocked", 32'(blocked), 32'd1);
        check("t6_async_mode_change", 32'(mode_change), 32'd0);
        check("t6_async_buses",
              32'(clk_btn_pulse | alm_btn_pulse | sw_btn_pulse | tmr_btn_pulse), 32'd0);
        wait_cycles(3);
        clr_sw_n = 1'b1;
        wait_cycles(20);

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_1k);
            if ($urandom_range(0, 11) == 0) begin
                idx = int'($urandom_range(0, N - 1));
                btn[idx] = ~btn[idx];
            end
            if ($urandom_range(0, 199) == 0)
                {alarm_sw, stopwatch_sw, timer_sw} = 3'($urandom);
        end
        wait_cycles(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
